div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Round-robin scheduler that shares one combinational `divider` instance between NREQ requesters.
- Each requester uses a valid/ready request channel.
- A single shared response channel returns quotient, remainder, divide-by-zero flag and requester ID.
- Sits between client blocks and the divider. It registers operands and results, so the combinational divider path is isolated between flops.

Parameters:
- WIDTH, 8, operand/result bit width; passed to divider as its width parameter.
- NREQ, 2, number of requesters, 2..8.
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  dividends, flattened; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  divisors, flattened the same way.
- req_sign  in  NREQ  1 = signed division, 0 = unsigned.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_quot  out  WIDTH  quotient.
- rsp_rem  out  WIDTH  remainder.
- rsp_dz  out  1  divide-by-zero flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_quot = 0, rsp_rem = 0, rsp_dz = 0.
- State machine IDLE -> EXEC -> RESP -> IDLE. Encoding 2 bits.
- IDLE:
  - req_ready is the combinational one-hot grant: first requester with req_valid set, searching upward from the rr pointer and wrapping at NREQ.
  - On a grant to i: latch a, b, sign and id i; pointer <= (i+1) mod NREQ; go to EXEC.
  - No valid requests: stay in IDLE, pointer unchanged.
- EXEC (one cycle): latched operands drive the divider; its outputs are registered into rsp_* at the clock edge; go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* fields are stable until the handshake.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - req_ready = 0 throughout EXEC and RESP.
- Latency and throughput:
  - Request accepted in cycle T -> rsp_valid high from cycle T+2.
  - Minimum spacing between accepts is 3 cycles when rsp_ready is held high.
- Arithmetic:
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Unsigned division treats operands as plain binary.
- Divide by zero (b == 0), divider output bypassed:
  - rsp_quot = all ones, rsp_rem = a, rsp_dz = 1.
- Signed overflow (sign=1, a = most negative value, b = -1):
  - rsp_quot = a (two's-complement wrap), rsp_rem = 0, rsp_dz = 0.
- Request inputs are sampled only in the accept cycle; changes afterwards have no effect on the result.
- A requester may drop req_valid before it is granted; it is then simply not selected.
- Reset mid-operation discards the in-flight request with no response; pointer returns to 0.

Optional Feature:
- Macro: DIV_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_ops (32 bit) and stat_dz (32 bit).
  - stat_ops increments on each response handshake; stat_dz increments on each handshake with rsp_dz = 1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports still exist, tied to 0; no counter logic is generated.

Decomposition:
- Header div_sched_defs.vh, shared with clients:
  - State encodings: IDLE=0, EXEC=1, RESP=2.
  - Divide-by-zero quotient constant (all ones).
  - Stats counter width (32).
- Sub-module rr_arbiter (parameter NREQ): inputs req, ptr, enable; outputs one-hot grant and encoded index.
- The existing divider is instantiated unchanged.

Test Plan:
- Single request, WIDTH=8: requester 0, a=42, b=7, sign=1 -> rsp_valid at T+2 with quot=6, rem=0, dz=0, id=0.
- Signed cases: a=-42, b=7 -> quot=-6, rem=0; a=7, b=-42 -> quot=0, rem=7; a=127, b=37 -> quot=3, rem=16.
- Fairness: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; accepts 3 cycles apart.
- Corner cases:
  - a=10, b=0 -> quot=255, rem=10, dz=1.
  - sign=1, a=-128, b=-1 -> quot=-128, rem=0, dz=0.
  - sign=0, a=200, b=7 -> quot=28, rem=4.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid and all rsp_* stable, req_ready=0 throughout; accept resumes the cycle after the handshake.
- Reset in EXEC: rst_n low mid-op -> outputs zero immediately, no response; after release the next grant goes to requester 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared definitions for div_sched and its clients: FSM encoding,
// divide-by-zero quotient fill and statistics counter width.
package div_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Every quotient bit is set to this value when the divisor is zero.
  localparam logic DZ_QUOT_BIT = 1'b1;

  localparam int STAT_W = 32;

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping at NREQ. Grant is forced low when enable is low.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (enable && !found && req[j] && (j == (int'(ptr) + k) % NREQ)) begin
          grant[j] = 1'b1;
          idx      = IDW'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/divider.sv
// Shared combinational divider: signed (truncating toward zero, remainder
// follows the dividend) or unsigned. A zero divisor yields zeros.
module divider #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // Magnitude division; the most negative value wraps back to itself.
  always_comb begin
    neg_a = sign & a[WIDTH-1];
    neg_b = sign & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    uq    = '0;
    ur    = '0;
    if (mag_b != '0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? -uq : uq;
    rem  = neg_a ? -ur : ur;
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one divider between NREQ requesters.
// Optional response counters enabled by DIV_SCHED_STATS_EN.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quot,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  rsp_dz,
  output state_t                dbg_state,
  output logic [STAT_W-1:0]     stat_ops,
  output logic [STAT_W-1:0]     stat_dz
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and rsp_* hold while rsp_valid is
  // high and rsp_ready is low.

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             arb_en;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sign;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic             lat_sign;
  logic [IDW-1:0]   lat_id;
  logic [WIDTH-1:0] div_q, div_r;

  assign arb_en    = rst_n && (state == ST_IDLE);
  assign accept    = |grant;
  assign req_ready = grant;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign dbg_state = state;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .enable(arb_en),
    .grant (grant),
    .idx   (grant_idx)
  );

  divider #(.WIDTH(WIDTH)) u_div (
    .a   (lat_a),
    .b   (lat_b),
    .sign(lat_sign),
    .quot(div_q),
    .rem (div_r)
  );

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_sign = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[i*WIDTH +: WIDTH];
        sel_b    = req_b[i*WIDTH +: WIDTH];
        sel_sign = req_sign[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_sign <= 1'b0;
      lat_id   <= '0;
      rsp_id   <= '0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
      rsp_dz   <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept) begin
        lat_a    <= sel_a;
        lat_b    <= sel_b;
        lat_sign <= sel_sign;
        lat_id   <= grant_idx;
        ptr      <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
      end
      // Zero divisor bypasses the divider entirely.
      if (state == ST_EXEC) begin
        rsp_id <= lat_id;
        if (lat_b == '0) begin
          rsp_quot <= {WIDTH{DZ_QUOT_BIT}};
          rsp_rem  <= lat_a;
          rsp_dz   <= 1'b1;
        end else begin
          rsp_quot <= div_q;
          rsp_rem  <= div_r;
          rsp_dz   <= 1'b0;
        end
      end
    end
  end

`ifdef DIV_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_dz  <= '0;
    end else if (rsp_fire) begin
      stat_ops <= stat_ops + 1'b1;
      if (rsp_dz) stat_dz <= stat_dz + 1'b1;
    end
  end
`else
  assign stat_ops = '0;
  assign stat_dz  = '0;
`endif

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed requests against a behavioural model of
// arbitration, latency and arithmetic, checked every cycle on the falling edge.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int W   = 8;
  localparam int N   = 2;
  localparam int IDW = 3;
  localparam int EW  = IDW + 2 * W + 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sign;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_quot;
  logic [W-1:0]   rsp_rem;
  logic           rsp_dz;
  state_t         dbg_state;
  logic [31:0]    stat_ops;
  logic [31:0]    stat_dz;

  div_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_sign (req_sign),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_quot (rsp_quot),
    .rsp_rem  (rsp_rem),
    .rsp_dz   (rsp_dz),
    .dbg_state(dbg_state),
    .stat_ops (stat_ops),
    .stat_dz  (stat_dz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int            cyc = 0;
  bit            m_busy = 0;
  int            m_resp_at = 0;
  int            m_ptr = 0;
  logic [N-1:0]  m_grant = '0;
  logic [EW-1:0] exp_q[$];
  int            acc_id[$];
  int            acc_cyc[$];
  logic [31:0]   m_ops = '0;
  logic [31:0]   m_dz = '0;

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb, iq, ir;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      iq = sa / sb;
      ir = sa % sb;
      q  = W'(iq);
      r  = W'(ir);
      dz = 1'b0;
    end
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g == '0 && req_valid[j]) g = N'(1) << j;
      end
    end
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
      exp_q.delete();
      acc_id.delete();
      acc_cyc.delete();
      m_ops  = '0;
      m_dz   = '0;
    end else begin
      if (m_busy && cyc >= m_resp_at) begin
        if (rsp_ready) begin
`ifdef DIV_SCHED_STATS_EN
          m_ops = m_ops + 1;
          if (exp_q.size() > 0 && exp_q[0][0]) m_dz = m_dz + 1;
`endif
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_busy = 0;
        end
      end else if (!m_busy && m_grant != '0) begin
        for (int j = 0; j < N; j++) begin
          if (m_grant[j]) begin
            logic [W-1:0] q, r;
            logic dz;
            ref_div(req_a[j*W +: W], req_b[j*W +: W], req_sign[j], q, r, dz);
            exp_q.push_back({IDW'(j), q, r, dz});
            acc_id.push_back(j);
            acc_cyc.push_back(cyc);
            m_ptr = (j + 1) % N;
          end
        end
        m_busy    = 1;
        m_resp_at = cyc + 2;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      m_grant = '0;
      chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz}, '0);
      chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("reset_stats", {stat_ops, stat_dz}, '0);
    end else begin
      logic exp_v;
      m_grant = model_grant();
      chk("req_ready", 64'(req_ready), 64'(m_grant));
      exp_v = m_busy && (cyc >= m_resp_at);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rsp_fields: response with empty expected queue at %0t", $time);
        end else begin
          chk("rsp_fields", {rsp_id, rsp_quot, rsp_rem, rsp_dz}, 64'(exp_q[0]));
        end
      end
      chk("stat_ops", 64'(stat_ops), 64'(m_ops));
      chk("stat_dz", 64'(stat_dz), 64'(m_dz));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    logic [W-1:0] mq, mr;
    logic mdz;
    bit got;
    ref_div(a, b, s, mq, mr, mdz);
    chk("model_pin", {mq, mr, mdz}, {eq, er, edz});
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sign[i]     = s;
    req_valid[i]    = 1'b1;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: requester %0d not granted, wanted grant within 30 cycles", i);
    end
    @(posedge clk);
    #1;
    req_valid[i]    = 1'b0;
    req_a[i*W +: W] = ~a;
    req_b[i*W +: W] = ~b;
    req_sign[i]     = ~s;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (!m_busy) done = 1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: response still pending, wanted none after 60 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids[4];
    bit got;
    exp_ids   = '{0, 1, 0, 1};
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic and signed arithmetic
    issue(0, 8'd42,  8'd7,   1'b1, 8'd6,   8'd0,  1'b0);
    issue(1, 8'd214, 8'd7,   1'b1, 8'd250, 8'd0,  1'b0);
    issue(0, 8'd7,   8'd214, 1'b1, 8'd0,   8'd7,  1'b0);
    issue(1, 8'd127, 8'd37,  1'b1, 8'd3,   8'd16, 1'b0);
    // Corner cases
    issue(0, 8'd10,  8'd0,   1'b1, 8'd255, 8'd10, 1'b1);
    issue(1, 8'd128, 8'd255, 1'b1, 8'd128, 8'd0,  1'b0);
    issue(0, 8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0);
    wait_idle();

    // Backpressure with a second requester waiting
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1, 8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0);
    req_a[0 +: W] = 8'd60;
    req_b[0 +: W] = 8'd6;
    req_sign[0]   = 1'b0;
    req_valid[0]  = 1'b1;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(0, 8'd60, 8'd6, 1'b0, 8'd10, 8'd0, 1'b0);
    wait_idle();

    // Reset while in EXEC, then fairness from pointer 0
    @(posedge clk);
    #1;
    req_a[0 +: W] = 8'd50;
    req_b[0 +: W] = 8'd5;
    req_valid[0]  = 1'b1;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    chk("exec_accept_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b0;
    #1 chk("async_reset", {rsp_valid, req_ready, rsp_id, rsp_quot, rsp_rem, rsp_dz}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_a     = {8'd77, 8'd90};
    req_b     = {8'd5, 8'd9};
    req_sign  = '0;
    req_valid = 2'b11;
    repeat (14) @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    if (acc_id.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("fair_order", 64'(acc_id[k]), 64'(exp_ids[k]));
      for (int k = 0; k < 3; k++) chk("accept_spacing", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd3);
    end else begin
      checks++;
      fails++;
      $display("FAIL fair_count: %0d accepts logged, wanted at least 4", acc_id.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
